// File: rtl/mem_port_arbiter_if.sv
// ------------------------------------------------------------------
// mem_port_arbiter_if : fetch, load/store and RAM port bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int ADDR_W = 14
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [2:0]        ls_funct3;
   logic [ADDR_W-1:0] ls_addr;
   logic [31:0]       ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [31:0]       ls_rdata;
   logic              ls_err;

   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   // Arbiter side
   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
      output ls_gnt, ls_rvalid, ls_rdata, ls_err,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Requester / RAM side
   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
      input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ------------------------------------------------------------------
// mem_port_arbiter : shares one sync RAM port between fetch and LSU
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int MAX_STARVE = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   mem_port_arbiter_if.slave  bus
);

   localparam int               C_CNT_W     = $clog2(MAX_STARVE + 1);
   localparam logic [C_CNT_W-1:0] C_STARVE_MAX = C_CNT_W'(MAX_STARVE);

   logic [C_CNT_W-1:0] r_starve;
   logic               r_if_rvalid;
   logic               r_ls_rvalid;
   logic               r_ls_err;
   logic               r_ls_load;
   logic [1:0]         r_off;
   logic [2:0]         r_funct3;

   logic               w_if_win;
   logic               w_if_gnt;
   logic               w_ls_gnt;
   logic [1:0]         w_size;
   logic               w_illegal;
   logic               w_misalign;
   logic               w_bad;
   logic [31:0]        w_shift;
   logic [31:0]        w_ext;
   logic               w_unused_addr;

   assign w_unused_addr = ^bus.if_addr[1:0];

   // Fetch wins when LSU is idle or once it has lost MAX_STARVE times in a row
   assign w_if_win = bus.if_req && (!bus.ls_req || (r_starve >= C_STARVE_MAX));
   assign w_if_gnt = !reset && w_if_win;
   assign w_ls_gnt = !reset && bus.ls_req && !w_if_win;

   assign bus.if_gnt = w_if_gnt;
   assign bus.ls_gnt = w_ls_gnt;

   assign w_size     = bus.ls_funct3[1:0];
   assign w_illegal  = (w_size == 2'b11) ||
                       (bus.ls_funct3[2] && (bus.ls_we || (w_size == 2'b10)));
   assign w_misalign = ((w_size == 2'b01) && bus.ls_addr[0]) ||
                       ((w_size == 2'b10) && (bus.ls_addr[1:0] != 2'b00));
   assign w_bad      = w_illegal || w_misalign;

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'h0;
      bus.mem_addr  = '0;
      bus.mem_wdata = 32'h0;
      if (w_if_gnt) begin
         bus.mem_en   = 1'b1;
         bus.mem_be   = 4'hF;
         bus.mem_addr = bus.if_addr[ADDR_W-1:2];
      end else if (w_ls_gnt && !w_bad) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = bus.ls_we;
         bus.mem_addr = bus.ls_addr[ADDR_W-1:2];
         if (!bus.ls_we) begin
            bus.mem_be = 4'hF;
         end else begin
            case (w_size)
               2'b00: begin
                  bus.mem_be    = 4'b0001 << bus.ls_addr[1:0];
                  bus.mem_wdata = {4{bus.ls_wdata[7:0]}};
               end
               2'b01: begin
                  bus.mem_be    = 4'b0011 << bus.ls_addr[1:0];
                  bus.mem_wdata = {2{bus.ls_wdata[15:0]}};
               end
               default: begin
                  bus.mem_be    = 4'hF;
                  bus.mem_wdata = bus.ls_wdata;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve <= '0;
      end else if (!bus.if_req || w_if_gnt) begin
         r_starve <= '0;
      end else if (r_starve < C_STARVE_MAX) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_if_rvalid <= 1'b0;
         r_ls_rvalid <= 1'b0;
         r_ls_err    <= 1'b0;
         r_ls_load   <= 1'b0;
         r_off       <= 2'b00;
         r_funct3    <= 3'b000;
      end else begin
         r_if_rvalid <= w_if_gnt;
         r_ls_rvalid <= w_ls_gnt;
         r_ls_err    <= w_ls_gnt && w_bad;
         r_ls_load   <= w_ls_gnt && !bus.ls_we && !w_bad;
         if (w_ls_gnt) begin
            r_off    <= bus.ls_addr[1:0];
            r_funct3 <= bus.ls_funct3;
         end
      end
   end

   assign w_shift = bus.mem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ext = w_shift;
      case (r_funct3)
         3'b000:  w_ext = {{24{w_shift[7]}},  w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ext = {24'h0, w_shift[7:0]};
         3'b101:  w_ext = {16'h0, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

   // A response still in flight when reset rises is suppressed immediately
   assign bus.if_rvalid = r_if_rvalid && !reset;
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.ls_rvalid = r_ls_rvalid && !reset;
   assign bus.ls_err    = r_ls_err && !reset;
   assign bus.ls_rdata  = (r_ls_load && !reset) ? w_ext : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ------------------------------------------------------------------
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
   localparam int ADDR_W = 14;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_STARVE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous RAM behind the arbiter
   logic [31:0] ram [0:4095];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
         bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   task automatic drive_ls(input logic we, input logic [2:0] f3, input logic [13:0] addr,
                           input logic [31:0] wd);
      @(negedge clk);
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_funct3 = f3;
      bus.ls_addr = addr; bus.ls_wdata = wd;
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.ls_req = 1'b0; bus.if_req = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.if_req = 1'b1; bus.ls_req = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      checks++; if (bus.if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got=%b exp=0", bus.if_gnt); end
      checks++; if (bus.ls_gnt !== 1'b0) begin errors++; $display("FAIL rst_ls_gnt got=%b exp=0", bus.ls_gnt); end
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en); end
      checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be got=%h exp=0", bus.mem_be); end
      checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL rst_if_rvalid got=%b exp=0", bus.if_rvalid); end
      checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL rst_ls_rvalid got=%b exp=0", bus.ls_rvalid); end
      checks++; if (bus.ls_err !== 1'b0) begin errors++; $display("FAIL rst_ls_err got=%b exp=0", bus.ls_err); end
      @(negedge clk);
      reset = 1'b0; bus.if_req = 1'b0; bus.ls_req = 1'b0;
   endtask

   task automatic test_fetch();
      drive_ls(1'b1, 3'b010, 14'h0010, 32'hDEADBEEF);
      checks++; if (bus.mem_be !== 4'hF) begin errors++; $display("FAIL sw_be got=%h exp=f", bus.mem_be); end
      checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", bus.mem_wdata); end
      checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sw_we got=%b exp=1", bus.mem_we); end
      idle();
      checks++; if (bus.ls_rvalid !== 1'b1) begin errors++; $display("FAIL sw_ack got=%b exp=1", bus.ls_rvalid); end
      checks++; if (bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL sw_rdata got=%h exp=0", bus.ls_rdata); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.if_req = 1'b1; bus.if_addr = 14'h0010;
         #1;
         checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt[%0d] got=%b exp=1", i, bus.if_gnt); end
         checks++; if (bus.mem_addr !== 12'd4) begin errors++; $display("FAIL fetch_addr[%0d] got=%h exp=4", i, bus.mem_addr); end
         checks++; if (bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_be_we[%0d] got=%h/%b exp=f/0", i, bus.mem_be, bus.mem_we); end
         if (i > 0) begin
            checks++; if (bus.if_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid[%0d] got=%b exp=1", i, bus.if_rvalid); end
            checks++; if (bus.if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata[%0d] got=%h exp=deadbeef", i, bus.if_rdata); end
         end
      end
      idle();
      checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_last got=%b/%h exp=1/deadbeef", bus.if_rvalid, bus.if_rdata); end
      checks++; if (bus.mem_en !== 1'b0 || bus.mem_be !== 4'h0) begin errors++; $display("FAIL idle_mem got=%b/%h exp=0/0", bus.mem_en, bus.mem_be); end
      idle();
      checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got=%b exp=0", bus.if_rvalid); end
   endtask

   task automatic test_store_load();
      drive_ls(1'b1, 3'b000, 14'h0103, 32'h000000A5);
      checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL sb_gnt got=%b exp=1", bus.ls_gnt); end
      checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got=%b exp=1000", bus.mem_be); end
      checks++; if (bus.mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bus.mem_wdata); end
      checks++; if (bus.mem_addr !== 12'h040) begin errors++; $display("FAIL sb_addr got=%h exp=040", bus.mem_addr); end
      idle();
      checks++; if (bus.ls_rvalid !== 1'b1 || bus.ls_err !== 1'b0) begin errors++; $display("FAIL sb_ack got=%b/%b exp=1/0", bus.ls_rvalid, bus.ls_err); end
      drive_ls(1'b0, 3'b000, 14'h0103, 32'h0);
      checks++; if (bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin errors++; $display("FAIL lb_be_we got=%h/%b exp=f/0", bus.mem_be, bus.mem_we); end
      drive_ls(1'b0, 3'b100, 14'h0103, 32'h0);
      checks++; if (bus.ls_rdata !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffffa5", bus.ls_rdata); end
      checks++; if (bus.ls_rvalid !== 1'b1 || bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL b2b_rv_gnt got=%b/%b exp=1/1", bus.ls_rvalid, bus.ls_gnt); end
      idle();
      checks++; if (bus.ls_rdata !== 32'h000000A5) begin errors++; $display("FAIL lbu_rdata got=%h exp=000000a5", bus.ls_rdata); end
      idle();
      checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL ls_pulse got=%b exp=0", bus.ls_rvalid); end
   endtask

   task automatic test_half();
      drive_ls(1'b1, 3'b001, 14'h0202, 32'h00001234);
      checks++; if (bus.mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b exp=1100", bus.mem_be); end
      checks++; if (bus.mem_wdata !== 32'h12341234) begin errors++; $display("FAIL sh_wdata got=%h exp=12341234", bus.mem_wdata); end
      drive_ls(1'b0, 3'b001, 14'h0202, 32'h0);
      checks++; if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL sh_ack got=%b/%h exp=1/0", bus.ls_rvalid, bus.ls_rdata); end
      drive_ls(1'b0, 3'b001, 14'h0201, 32'h0);
      checks++; if (bus.ls_rdata !== 32'h00001234) begin errors++; $display("FAIL lh_rdata got=%h exp=00001234", bus.ls_rdata); end
      checks++; if (bus.ls_gnt !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_be !== 4'h0) begin errors++; $display("FAIL lh_mis_gnt_en_be got=%b/%b/%h exp=1/0/0", bus.ls_gnt, bus.mem_en, bus.mem_be); end
      idle();
      checks++; if (bus.ls_err !== 1'b1 || bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL lh_mis_err got=%b/%b/%h exp=1/1/0", bus.ls_err, bus.ls_rvalid, bus.ls_rdata); end
   endtask

   task automatic test_illegal();
      drive_ls(1'b0, 3'b011, 14'h0000, 32'h0);
      checks++; if (bus.ls_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL ill_ld_gnt_en got=%b/%b exp=1/0", bus.ls_gnt, bus.mem_en); end
      idle();
      checks++; if (bus.ls_err !== 1'b1 || bus.ls_rvalid !== 1'b1) begin errors++; $display("FAIL ill_ld_err got=%b/%b exp=1/1", bus.ls_err, bus.ls_rvalid); end
      drive_ls(1'b1, 3'b100, 14'h0000, 32'h0);
      checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL ill_st_en_we got=%b/%b exp=0/0", bus.mem_en, bus.mem_we); end
      idle();
      checks++; if (bus.ls_err !== 1'b1) begin errors++; $display("FAIL ill_st_err got=%b exp=1", bus.ls_err); end
      drive_ls(1'b0, 3'b010, 14'h0002, 32'h0);
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL lw_mis_en got=%b exp=0", bus.mem_en); end
      idle();
      checks++; if (bus.ls_err !== 1'b1) begin errors++; $display("FAIL lw_mis_err got=%b exp=1", bus.ls_err); end
   endtask

   task automatic test_starve();
      logic exp_if;
      logic prev_if;
      prev_if = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.if_req = 1'b1; bus.if_addr = 14'h0010;
         bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_funct3 = 3'b010; bus.ls_addr = 14'h0000;
         #1;
         exp_if = ((c % 5) == 4);
         checks++; if (bus.if_gnt !== exp_if || bus.ls_gnt !== !exp_if) begin errors++; $display("FAIL starve_gnt[%0d] if/ls got=%b/%b exp=%b/%b", c, bus.if_gnt, bus.ls_gnt, exp_if, !exp_if); end
         if (c > 0) begin
            checks++; if (bus.if_rvalid !== prev_if || bus.ls_rvalid !== !prev_if) begin errors++; $display("FAIL starve_rv[%0d] if/ls got=%b/%b exp=%b/%b", c, bus.if_rvalid, bus.ls_rvalid, prev_if, !prev_if); end
         end
         prev_if = exp_if;
      end
      idle();
      idle();
   endtask

   task automatic test_reset_mid();
      logic exp_if;
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 14'h0010;
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_funct3 = 3'b010; bus.ls_addr = 14'h0200;
      #1;
      checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt0 got=%b exp=1", bus.ls_gnt); end
      @(negedge clk); #1;
      checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt1 got=%b exp=1", bus.ls_gnt); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid got=%b exp=0", bus.ls_rvalid); end
      checks++; if (bus.ls_gnt !== 1'b0 || bus.if_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL rm_gnt_en got=%b/%b/%b exp=0/0/0", bus.ls_gnt, bus.if_gnt, bus.mem_en); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (bus.ls_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.ls_err !== 1'b0) begin errors++; $display("FAIL rm_stale got=%b/%b/%b exp=0/0/0", bus.ls_rvalid, bus.if_rvalid, bus.ls_err); end
      checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL rm_post_gnt0 got=%b exp=1", bus.ls_gnt); end
      for (int c = 1; c < 5; c++) begin
         @(negedge clk); #1;
         exp_if = (c == 4);
         checks++; if (bus.if_gnt !== exp_if || bus.ls_gnt !== !exp_if) begin errors++; $display("FAIL rm_post_gnt[%0d] if/ls got=%b/%b exp=%b/%b", c, bus.if_gnt, bus.ls_gnt, exp_if, !exp_if); end
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_funct3 = 3'b000;
      bus.ls_addr = '0; bus.ls_wdata = 32'h0;
      test_reset();
      test_fetch();
      test_store_load();
      test_half();
      test_illegal();
      test_starve();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port synchronous data RAM between the instruction-fetch unit and the load/store unit. Arbitrates one access per cycle with a starvation guard. Generates byte enables and write-data lane replication from the RISC-V funct3 size code. Aligns and sign/zero-extends load data on the return path, and flags misaligned or illegal-size accesses.

Parameters:
ADDR_W, 14, byte-address width of both requesters
MAX_STARVE, 4, consecutive cycles a pending fetch may lose before it is forced to win

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request (held until granted)
if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored)
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid
if_rdata  out  32  fetched word
ls_req  in  1  load/store request (held until granted)
ls_we  in  1  1 = store, 0 = load
ls_funct3  in  3  RISC-V size/sign code
ls_addr  in  ADDR_W  byte address
ls_wdata  in  32  store data, right-aligned
ls_gnt  out  1  load/store accepted this cycle
ls_rvalid  out  1  load data valid or store acknowledge
ls_rdata  out  32  aligned, extended load data (0 for stores and errors)
ls_err  out  1  misaligned or illegal funct3, coincident with ls_rvalid
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write
mem_be  out  4  RAM byte enables
mem_addr  out  ADDR_W-2  RAM word index
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid one cycle after mem_en

Behaviour:
- Reset: starve counter = 0; if_rvalid, ls_rvalid, ls_err = 0; pending-response registers cleared. Grants and mem_en are forced 0 while reset is high. A response pending at reset is dropped.
- Grants are combinational in the request cycle; at most one grant per cycle.
- Priority: ls wins over if, except when the starve counter has reached MAX_STARVE, in which case if wins.
- Starve counter:
  - increments (saturating at MAX_STARVE) each cycle if_req=1 and if_gnt=0;
  - clears on if_gnt;
  - clears when if_req=0.
- Fetch grant: mem_en=1, mem_we=0, mem_be=4'hF, mem_addr=if_addr[ADDR_W-1:2]. The next cycle gives if_rvalid=1 and if_rdata=mem_rdata.
- Load/store legality:
  - legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - legal store funct3: 000, 001, 010;
  - anything else is illegal;
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Illegal or misaligned access: still granted (consumed), mem_en=0. The next cycle gives ls_rvalid=1, ls_err=1, ls_rdata=0.
- Store grant:
  - mem_en=1, mem_we=1;
  - byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}};
  - half: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}};
  - word: be=4'hF, wdata=wdata;
  - next cycle: ls_rvalid=1, ls_rdata=0, ls_err=0.
- Load grant:
  - mem_en=1, mem_we=0, be=4'hF; funct3 and addr[1:0] are registered;
  - next cycle, the word is shifted right by 8*addr[1:0], then extended per funct3 (sign for 000/001, zero for 100/101);
  - ls_rvalid=1.
- Response registers are single-cycle pulses. Pipelining is allowed: a new grant may be issued in the same cycle a previous response is returned, so back-to-back accesses give one response per cycle.
- When mem_en=0, mem_we=0 and mem_be=0.
- Simultaneous reset and request: reset wins, no grant.

Test Plan:
- Fetch only: if_req=1, addr=0x0010 for 3 cycles with ls idle -> if_gnt each cycle, mem_addr=4,4,4; if_rvalid from cycle 1 with the RAM word.
- Store then load: SB wdata=0x000000A5 at 0x0103 -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5. Then LB 0x0103 -> ls_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
- Half alignment: SH 0x1234 at 0x0202, then LH 0x0202 -> be=4'b1100, rdata=0x00001234. LH at 0x0201 -> ls_err=1, mem_en=0, rdata=0.
- Starvation: if_req and ls_req held high continuously -> ls granted 4 cycles, if granted on the 5th, then ls 4 more; the counter never exceeds 4.
- Illegal funct3: load funct3=011 -> ls_gnt=1, mem_en=0, next cycle ls_err=1.
- Reset mid-load: assert reset in the response cycle of an LW -> ls_rvalid=0; after release no stale response appears and the counter is 0.
